frame_capture_ctrl: RTL

Sequences capture of one or more camera frames from the 8-bit YUV422/RGB565 byte stream on pclk. Frames are delimited by vsync/href. The block pairs bytes into 16-bit pixels and generates write addresses and write strobes for the frame-buffer memory. It arms on a start request and runs single-shot or continuous, reporting frame completion and geometry errors to the system side.

---
 rtl/frame_capture_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/frame_capture_ctrl.sv
// Camera byte-stream capture sequencer: pairs bytes into 16-bit pixels and
// generates frame-buffer write strobes/addresses between vsync-delimited frames.
module frame_capture_ctrl #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned ADDR_W   = 19,
   parameter int unsigned LINE_W   = 10
) (
   input  logic              pclk,
   input  logic              reset,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        byte_camera,
   input  logic              start,
   input  logic              continuous,
   output logic              busy,
   output logic              pixel_valid,
   output logic [15:0]       pixel_data,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [LINE_W-1:0] line_count,
   output logic              frame_done,
   output logic              frame_error,
   output logic [7:0]        frame_count
);

   typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE, DONE} state_t;

   localparam logic [LINE_W-1:0] H_LIM  = LINE_W'(H_ACTIVE);
   localparam logic [LINE_W-1:0] V_LIM  = LINE_W'(V_ACTIVE);
   localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

   state_t              state;
   logic                vsync_d;
   logic                href_d;
   logic                cont_q;
   logic                phase;
   logic [7:0]          hi;
   logic [LINE_W-1:0]   col;
   logic [ADDR_W-1:0]   line_base;

   logic                vs_rise;
   logic                vs_fall;
   logic                href_rise;
   logic                href_fall;
   logic                cur_phase;
   logic                in_bounds;
   logic                line_bad;
   logic [LINE_W-1:0]   lc_inc;
   logic [LINE_W-1:0]   lc_after;

   always_comb begin
      vs_rise   = vsync & ~vsync_d;
      vs_fall   = ~vsync & vsync_d;
      href_rise = href & ~href_d;
      href_fall = ~href & href_d;
      // A fresh line always starts pairing on the first byte.
      cur_phase = href_rise ? 1'b0 : phase;
      in_bounds = (col < H_LIM) && (line_count < V_LIM);
      line_bad  = (col != H_LIM) || phase;
      lc_inc    = (line_count == '1) ? line_count : line_count + 1'b1;
      lc_after  = href_fall ? lc_inc : line_count;
   end

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         vsync_d     <= 1'b0;
         href_d      <= 1'b0;
         cont_q      <= 1'b0;
         phase       <= 1'b0;
         hi          <= '0;
         col         <= '0;
         line_base   <= '0;
         busy        <= 1'b0;
         pixel_valid <= 1'b0;
         pixel_data  <= '0;
         wr_addr     <= '0;
         line_count  <= '0;
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
         frame_count <= '0;
      end else begin
         vsync_d     <= vsync;
         href_d      <= href;
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  state  <= WAIT_VS;
                  busy   <= 1'b1;
                  cont_q <= continuous;
               end
            end

            WAIT_VS: begin
               if (vs_fall) begin
                  state       <= ACTIVE;
                  col         <= '0;
                  line_count  <= '0;
                  line_base   <= '0;
                  phase       <= 1'b0;
                  frame_error <= 1'b0;
               end
            end

            ACTIVE: begin
               if (href_fall) begin
                  line_count <= lc_inc;
                  line_base  <= line_base + H_STEP;
                  col        <= '0;
                  phase      <= 1'b0;
                  if (line_bad)
                     frame_error <= 1'b1;
               end else if (href && !vs_rise) begin
                  phase <= ~cur_phase;
                  if (!cur_phase) begin
                     hi <= byte_camera;
                  end else if (in_bounds) begin
                     pixel_valid <= 1'b1;
                     pixel_data  <= {hi, byte_camera};
                     wr_addr     <= line_base + ADDR_W'(col);
                     col         <= col + 1'b1;
                  end else begin
                     frame_error <= 1'b1;
                  end
               end

               // Line-end bookkeeping above lands in the same edge as the frame end.
               if (vs_rise) begin
                  state       <= DONE;
                  frame_done  <= 1'b1;
                  frame_count <= frame_count + 8'd1;
                  phase       <= 1'b0;
                  if (href || (lc_after != V_LIM))
                     frame_error <= 1'b1;
               end
            end

            DONE: begin
               if (cont_q) begin
                  state <= WAIT_VS;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
